// File: rtl/spi_port.sv
// spi_port: 68000-bus SPI master (mode 0, MSB first) with DATA, CTRL/STATUS and DIV registers.
//   Bus side : REG_SEL/A_REG/AS_CPU_n/DS_n/RW_n/D_IN in, D_OUT/D_OE/DTACK_n out.
//   SPI side : SPI_CS/SPI_SCK/SPI_MOSI out, SPI_MISO in (double-registered).
//   CLKCPU is the only clock; RESET_n is asynchronous, active-low.
module spi_port #(
    parameter logic [7:0] DIV_RESET = 8'd63,
    parameter logic [7:0] RX_RESET  = 8'hFF
) (
    input  logic       CLKCPU,
    input  logic       RESET_n,
    input  logic       REG_SEL,
    input  logic [1:0] A_REG,
    input  logic       AS_CPU_n,
    input  logic       DS_n,
    input  logic       RW_n,
    input  logic [7:0] D_IN,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    output logic       DTACK_n,
    output logic       SPI_CS,
    output logic       SPI_SCK,
    output logic       SPI_MOSI,
    input  logic       SPI_MISO
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;
    localparam logic [1:0] R_DATA = 2'd0;
    localparam logic [1:0] R_CTRL = 2'd1;
    localparam logic [1:0] R_DIV  = 2'd2;
    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx, tx, tx_nx, rx_sh, rx_sh_nx, rx, rx_nx, div;
    logic [2:0] bits, bits_nx;
    logic       armed, dtack_n, cs, sck, mosi, miso_m, miso_s;
    logic       access, first, wr, busy, phase_end, start;
    assign access    = REG_SEL & ~AS_CPU_n & ~DS_n;
    // A bus cycle acts only on its first edge; armed drops until AS_CPU_n returns high.
    assign first     = access & armed;
    assign wr        = first & ~RW_n;
    assign busy      = state != IDLE;
    assign phase_end = cnt == div;
    assign start     = wr & (A_REG == R_DATA) & ~busy;
    assign D_OE      = access & RW_n & RESET_n;
    assign DTACK_n   = dtack_n;
    assign SPI_CS    = cs;
    assign SPI_SCK   = sck;
    assign SPI_MOSI  = mosi;
    always_comb
        D_OUT = (A_REG == R_DATA) ? rx :
                (A_REG == R_CTRL) ? {busy, 6'b0, cs} :
                (A_REG == R_DIV)  ? div : 8'h00;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bits_nx  = bits;
        tx_nx    = tx;
        rx_sh_nx = rx_sh;
        rx_nx    = rx;
        case (state)
            IDLE: if (start) begin
                state_nx = LOW;
                cnt_nx   = 8'd0;
                bits_nx  = 3'd0;
                tx_nx    = D_IN;
            end
            LOW: if (phase_end) begin
                state_nx = HIGH;
                cnt_nx   = 8'd0;
                rx_sh_nx = {rx_sh[6:0], miso_s};
            end else begin
                cnt_nx = cnt + 8'd1;
            end
            HIGH: if (phase_end) begin
                cnt_nx = 8'd0;
                if (bits == 3'd7) begin
                    state_nx = IDLE;
                    rx_nx    = rx_sh;
                end else begin
                    state_nx = LOW;
                    bits_nx  = bits + 3'd1;
                    tx_nx    = {tx[6:0], 1'b0};
                end
            end else begin
                cnt_nx = cnt + 8'd1;
            end
            default: state_nx = IDLE;
        endcase
    end
    // SCK and MOSI come straight from flops so the pins never glitch on state decode.
    always_ff @(posedge CLKCPU or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            bits  <= 3'd0;
            tx    <= 8'd0;
            rx_sh <= 8'd0;
            rx    <= RX_RESET;
            sck   <= 1'b0;
            mosi  <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            bits  <= bits_nx;
            tx    <= tx_nx;
            rx_sh <= rx_sh_nx;
            rx    <= rx_nx;
            sck   <= state_nx == HIGH;
            mosi  <= (state_nx == IDLE) ? 1'b1 : tx_nx[7];
        end
    end
    always_ff @(posedge CLKCPU or negedge RESET_n) begin
        if (!RESET_n) begin
            armed   <= 1'b1;
            dtack_n <= 1'b1;
            cs      <= 1'b1;
            div     <= DIV_RESET;
            miso_m  <= 1'b0;
            miso_s  <= 1'b0;
        end else begin
            miso_m <= SPI_MISO;
            miso_s <= miso_m;
            if (AS_CPU_n) begin
                armed   <= 1'b1;
                dtack_n <= 1'b1;
            end else if (first) begin
                armed   <= 1'b0;
                dtack_n <= 1'b0;
            end
            if (wr && A_REG == R_CTRL)
                cs <= D_IN[0];
            if (wr && A_REG == R_DIV && !busy)
                div <= D_IN;
        end
    end
endmodule
